calc_alu_seq: RTL and testbench
===============================

// Module: calc_alu_seq
// PURPOSE
//  Parametrised sequential arithmetic core for the calculator datapath; next generation of the calculat unit.
//  Sits between the keyboard decoder (operands, op code, en) and the display path (data3, data_latch).
//  Adds signed add/sub/mul/div/mod/pass over DW-bit operands, with a multi-cycle shift-add multiplier.
//  Adds a multi-cycle restoring divider, an en/busy handshake, a one-cycle result strobe and an error flag.
// PARAMETERS
//  DW    27       operand width, signed two's complement, DW>=4
//  OW    2*DW     result width (derived localparam, not overridable)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  en          in   1    start request, sampled only when busy=0
//  arith       in   3    op: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 pass data1, 11x illegal
//  data1       in   DW   signed operand A (dividend / multiplicand)
//  data2       in   DW   signed operand B (divisor / multiplier)
//  data3       out  OW   signed result, registered, held until next DONE
//  data_latch  out  1    one-cycle strobe: data3/err valid
//  busy        out  1    high while an operation is in flight
//  err         out  1    registered; updated every DONE; 1 = div/mod by zero or illegal op
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; data3=0, data_latch=0, busy=0, err=0; internal regs cleared.
//  Reset mid-operation aborts with no data_latch; first en after release starts cleanly.
//  FSM: IDLE -> CALC -> [FIX] -> DONE -> IDLE.
//  IDLE: en=1 at edge t captures data1, data2, arith; busy=1 from t+1. en=0 stays IDLE.
//  en while busy=1 (CALC/FIX/DONE) is ignored; inputs may change freely after capture.
//  add/sub/pass: operands sign-extended to OW, computed in CALC (1 cycle); DONE at t+2.
//  add/sub/pass never overflow because OW>DW+1.
//  mul: magnitudes |A|,|B| in OW-bit regs; CALC runs DW cycles of shift-add; FIX applies sign (A^B); DONE at t+DW+2.
//  div/mod: restoring division on magnitudes; CALC runs DW cycles; FIX applies signs; DONE at t+DW+2.
//  div: quotient truncates toward zero, sign = signA^signB; quotient sign-extended to OW.
//  div: -2^(DW-1)/-1 = +2^(DW-1) is representable in OW, no overflow.
//  mod: remainder sign follows dividend (Verilog %): 1000 % -7 = 6, -1000 % 7 = -6.
//  |-2^(DW-1)| must be formed in DW+1 bits or wider: no magnitude wrap.
//  data2=0 with div/mod: skip CALC; DONE at t+2, err=1, data3=0.
//  Illegal op (11x): DONE at t+2, err=1, data3=0.
//  All other ops: err=0 at DONE.
//  DONE: data3 and err update on entry; data_latch=1 for exactly this cycle; busy still 1.
//  busy=0 from the following cycle (IDLE); back-to-back en accepted in that IDLE cycle.
//  Minimum spacing between starts: 3 cycles for single-cycle ops.
//  data_latch never asserts twice per en; never asserts without a preceding accepted en.
// TESTING (default DW=27, OW=54; t = edge sampling en)
//  1) add: data1=100, data2=-250, arith=000, en -> t+1 busy=1; t+2 data_latch=1, data3=-150, err=0; t+3 busy=0.
//  2) mul: -12345 * 678 -> data3=-8369910 at t+29 (DW+2).
//  2) mul corner: (-2^26)*(-2^26) -> data3=2^52, err=0.
//  3) div/mod: 1000 / -7 -> -142 at t+29; 1000 % -7 -> 6; -1000 % 7 -> -6.
//  3) DW=8 instance: -128 / -1 -> data3=128.
//  4) div by zero: 55/0 -> t+2 data_latch=1, err=1, data3=0.
//  4) op 110 -> err=1, data3=0.
//  4) next valid add -> err=0.
//  5) handshake: en pulsed every cycle during a mul -> exactly one data_latch.
//  5) handshake: captured operands unchanged by mid-op input edits.
//  5) handshake: en in the IDLE cycle after DONE is accepted.
//  6) reset: rst_n=0 async at t+10 of a mul -> outputs 0 immediately, no strobe.
//  6) reset: after release, 3+4 add -> data3=7 at t'+2.

Source files
------------

// File: rtl/calc_alu_seq.sv
// -----------------------------------------------------------------------------
// calc_alu_seq
//   Sequential signed arithmetic core for the calculator datapath.
//   Accepts a request (operands + op code) through an en/busy handshake and
//   produces a registered OW-bit signed result plus a one-cycle strobe.
//   add/sub/pass finish in one CALC cycle. mul uses a DW-step shift-add on the
//   operand magnitudes. div/mod use a DW-step restoring divider on magnitudes.
//   FIX then restores the signs.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for en; operands captured on the accepting edge
//   CALC  | single-cycle ops resolve here; mul/div/mod iterate DW cycles
//   FIX   | apply result sign to the magnitude result of mul/div/mod
//   DONE  | data3/err just updated, data_latch high for this one cycle
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          start request, sampled only in IDLE
//   i_arith[2:0]  000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 pass, 11x illegal
//   i_data1       signed operand A (dividend / multiplicand)
//   i_data2       signed operand B (divisor / multiplier)
//   o_data3       signed result, held until the next DONE
//   o_data_latch  one-cycle strobe, o_data3/o_err valid
//   o_busy        high while an operation is in flight
//   o_err         divide/modulo by zero or illegal op, updated at every DONE
// -----------------------------------------------------------------------------
module calc_alu_seq #(
    parameter int DW = 27
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [2:0]        i_arith,
    input  logic [DW-1:0]     i_data1,
    input  logic [DW-1:0]     i_data2,
    output logic [2*DW-1:0]   o_data3,
    output logic              o_data_latch,
    output logic              o_busy,
    output logic              o_err
);

    localparam int OW = 2 * DW;
    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    logic [1:0]    r_state;
    logic [2:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_neg;      // sign of product / quotient
    logic          r_sign_a;   // sign of remainder follows the dividend
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_acc;
    logic [OW-1:0] r_mcand;
    logic [DW:0]   r_mplier;
    logic [DW:0]   r_div;
    logic [DW:0]   r_rem;
    logic [DW-1:0] r_quo;
    logic [OW-1:0] r_data3;
    logic          r_latch;
    logic          r_err;

    logic [OW-1:0] w_ext1;
    logic [OW-1:0] w_mag_a;
    logic [DW:0]   w_ext2;
    logic [DW:0]   w_mag_b;
    logic [OW-1:0] w_a_ext;
    logic [OW-1:0] w_b_ext;
    logic          w_b_zero;
    logic          w_iter;
    logic [DW:0]   w_rem_sh;
    logic          w_ge;
    logic [DW:0]   w_rem_nx;
    logic [OW-1:0] w_quo_ext;
    logic [OW-1:0] w_rem_ext;
    logic [OW-1:0] w_single;
    logic          w_single_err;
    logic [OW-1:0] w_fix;

    // Magnitudes are formed wider than DW so |-2^(DW-1)| does not wrap.
    assign w_ext1  = {{(OW-DW){i_data1[DW-1]}}, i_data1};
    assign w_mag_a = i_data1[DW-1] ? -w_ext1 : w_ext1;
    assign w_ext2  = {i_data2[DW-1], i_data2};
    assign w_mag_b = i_data2[DW-1] ? -w_ext2 : w_ext2;

    assign w_a_ext  = {{(OW-DW){r_a[DW-1]}}, r_a};
    assign w_b_ext  = {{(OW-DW){r_b[DW-1]}}, r_b};
    assign w_b_zero = (r_b == '0);
    assign w_iter   = (r_op == OP_MUL) ||
                      (((r_op == OP_DIV) || (r_op == OP_MOD)) && !w_b_zero);

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits.
    assign w_rem_sh = {r_rem[DW-1:0], r_quo[DW-1]};
    assign w_ge     = (w_rem_sh >= r_div);
    assign w_rem_nx = w_ge ? (w_rem_sh - r_div) : w_rem_sh;

    assign w_quo_ext = {{(OW-DW){1'b0}}, r_quo};
    assign w_rem_ext = {{(OW-DW-1){1'b0}}, r_rem};

    always_comb begin
        w_single     = '0;
        w_single_err = 1'b0;
        case (r_op)
            OP_ADD:  w_single = w_a_ext + w_b_ext;
            OP_SUB:  w_single = w_a_ext - w_b_ext;
            OP_PASS: w_single = w_a_ext;
            OP_DIV,
            OP_MOD:  w_single_err = 1'b1;   // only reached with a zero divisor
            default: w_single_err = 1'b1;
        endcase
    end

    always_comb begin
        w_fix = '0;
        case (r_op)
            OP_MUL:  w_fix = r_neg    ? -r_acc     : r_acc;
            OP_DIV:  w_fix = r_neg    ? -w_quo_ext : w_quo_ext;
            default: w_fix = r_sign_a ? -w_rem_ext : w_rem_ext;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_sign_a <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_data3  <= '0;
            r_latch  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_latch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_op     <= i_arith;
                        r_a      <= i_data1;
                        r_b      <= i_data2;
                        r_neg    <= i_data1[DW-1] ^ i_data2[DW-1];
                        r_sign_a <= i_data1[DW-1];
                        r_cnt    <= CW'(DW - 1);
                        r_acc    <= '0;
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_div    <= w_mag_b;
                        r_rem    <= '0;
                        r_quo    <= w_mag_a[DW-1:0];
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!w_iter) begin
                        r_data3 <= w_single;
                        r_err   <= w_single_err;
                        r_latch <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (r_op == OP_MUL) begin
                            if (r_mplier[0]) begin
                                r_acc <= r_acc + r_mcand;
                            end
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                        end else begin
                            r_rem <= w_rem_nx;
                            r_quo <= {r_quo[DW-2:0], w_ge};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_data3 <= w_fix;
                    r_err   <= 1'b0;
                    r_latch <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data3      = r_data3;
    assign o_data_latch = r_latch;
    assign o_err        = r_err;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_calc_alu_seq.sv
module tb_calc_alu_seq;

    localparam int DW = 27;
    localparam int OW = 54;
    localparam int LONG_LAT = DW + 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [2:0]    arith;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [OW-1:0] data3;
    logic          data_latch;
    logic          busy;
    logic          err;

    logic          en8;
    logic [2:0]    arith8;
    logic [7:0]    d1_8;
    logic [7:0]    d2_8;
    logic [15:0]   data3_8;
    logic          latch8;
    logic          busy8;
    logic          err8;

    int n_checks = 0;
    int n_errors = 0;

    calc_alu_seq #(.DW(DW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_arith(arith),
        .i_data1(data1), .i_data2(data2), .o_data3(data3),
        .o_data_latch(data_latch), .o_busy(busy), .o_err(err)
    );

    calc_alu_seq #(.DW(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en8), .i_arith(arith8),
        .i_data1(d1_8), .i_data2(d2_8), .o_data3(data3_8),
        .o_data_latch(latch8), .o_busy(busy8), .o_err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]           op;
        logic signed [DW-1:0] d1;
        logic signed [DW-1:0] d2;
        logic signed [OW-1:0] exp;
        logic                 exp_err;
        int                   lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain signed 64-bit arithmetic on the sign-extended operands.
    function automatic logic [OW-1:0] ref_res(input logic [2:0] op, input logic signed [DW-1:0] d1,
                                             input logic signed [DW-1:0] d2, output logic e);
        longint a = d1;
        longint b = d2;
        longint r = 0;
        e = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: if (b == 0) e = 1'b1; else r = a / b;
            3'd4: if (b == 0) e = 1'b1; else r = a % b;
            3'd5: r = a;
            default: e = 1'b1;
        endcase
        return r[OW-1:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [DW-1:0] d2);
        if (op == 3'd2) return LONG_LAT;
        if ((op == 3'd3 || op == 3'd4) && d2 != '0) return LONG_LAT;
        return 2;
    endfunction

    // Starts one operation in the current (IDLE) cycle and follows it through DONE
    // into the next IDLE cycle. With mess=1 the inputs and en are scrambled while busy.
    task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [OW-1:0] exp_d3,
                          input logic exp_err, input int exp_lat, input bit mess);
        int  k;
        bit  seen;
        en = 1'b1; arith = op; data1 = d1; data2 = d2;
        tick();
        k = 1;
        en = 1'b0;
        chk($sformatf("%s busy_t1", name), {53'd0, busy}, 54'd1);
        if (exp_lat > 2) chk($sformatf("%s no_early_latch", name), {53'd0, data_latch}, 54'd0);
        seen = 1'b0;
        while (!seen && k < 60) begin
            if (mess) begin
                en = 1'($urandom_range(0, 1));
                arith = 3'($urandom);
                data1 = DW'($urandom);
                data2 = DW'($urandom);
            end
            tick();
            k++;
            if (data_latch) seen = 1'b1;
        end
        if (!seen) begin
            chk($sformatf("%s timeout", name), 54'd0, 54'd1);
        end else begin
            chk($sformatf("%s latency", name), OW'(k), OW'(exp_lat));
            chk($sformatf("%s data3", name), data3, exp_d3);
            chk($sformatf("%s err", name), {53'd0, err}, {53'd0, exp_err});
            chk($sformatf("%s busy_done", name), {53'd0, busy}, 54'd1);
        end
        en = 1'b0;
        tick();
        chk($sformatf("%s busy_idle", name), {53'd0, busy}, 54'd0);
        chk($sformatf("%s latch_once", name), {53'd0, data_latch}, 54'd0);
    endtask

    task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_d3);
        int k;
        bit seen;
        en8 = 1'b1; arith8 = op; d1_8 = a; d2_8 = b;
        tick();
        k = 1;
        en8 = 1'b0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (latch8) seen = 1'b1;
        end
        if (!seen) begin
            chk($sformatf("%s timeout", name), 54'd0, 54'd1);
        end else begin
            chk($sformatf("%s latency", name), OW'(k), 54'd10);
            chk($sformatf("%s data3", name), {38'd0, data3_8}, {38'd0, exp_d3});
            chk($sformatf("%s err", name), {53'd0, err8}, 54'd0);
        end
        tick();
    endtask

    initial begin
        logic [OW-1:0] e_d3;
        logic          e_err;
        logic [2:0]    r_op;
        logic [DW-1:0] r_d1;
        logic [DW-1:0] r_d2;
        logic [DW-1:0] corner [5];
        int            k;

        vecs[0]  = '{3'd0, 27'sd100, -27'sd250, -54'sd150, 1'b0, 2};
        vecs[1]  = '{3'd2, -27'sd12345, 27'sd678, -54'sd8369910, 1'b0, LONG_LAT};
        vecs[2]  = '{3'd2, 27'h4000000, 27'h4000000, 54'h10000000000000, 1'b0, LONG_LAT};
        vecs[3]  = '{3'd3, 27'sd1000, -27'sd7, -54'sd142, 1'b0, LONG_LAT};
        vecs[4]  = '{3'd4, 27'sd1000, -27'sd7, 54'sd6, 1'b0, LONG_LAT};
        vecs[5]  = '{3'd4, -27'sd1000, 27'sd7, -54'sd6, 1'b0, LONG_LAT};
        vecs[6]  = '{3'd3, 27'sd55, 27'sd0, 54'sd0, 1'b1, 2};
        vecs[7]  = '{3'd6, 27'sd5, 27'sd5, 54'sd0, 1'b1, 2};
        vecs[8]  = '{3'd0, 27'sd3, 27'sd4, 54'sd7, 1'b0, 2};
        vecs[9]  = '{3'd3, 27'h4000000, -27'sd1, 54'sd67108864, 1'b0, LONG_LAT};
        vecs[10] = '{3'd1, -27'sd5, 27'sd67108863, -54'sd67108868, 1'b0, 2};
        vecs[11] = '{3'd5, -27'sd77, 27'sd9, -54'sd77, 1'b0, 2};
        vecs[12] = '{3'd4, 27'sd9, 27'sd0, 54'sd0, 1'b1, 2};
        vecs[13] = '{3'd7, 27'sd1, 27'sd2, 54'sd0, 1'b1, 2};
        vecs[14] = '{3'd2, 27'sd67108863, 27'h4000000, -54'sd4503599560261632, 1'b0, LONG_LAT};
        vecs[15] = '{3'd3, 27'sd7, 27'sd9, 54'sd0, 1'b0, LONG_LAT};
        vecs[16] = '{3'd4, -27'sd7, 27'sd9, -54'sd7, 1'b0, LONG_LAT};

        corner[0] = 27'h4000000;
        corner[1] = 27'h3FFFFFF;
        corner[2] = 27'h7FFFFFF;
        corner[3] = 27'h0000001;
        corner[4] = 27'h0000000;

        rst_n = 1'b0; en = 1'b0; arith = '0; data1 = '0; data2 = '0;
        en8 = 1'b0; arith8 = '0; d1_8 = '0; d2_8 = '0;
        #3;
        chk("reset data3", data3, 54'd0);
        chk("reset latch", {53'd0, data_latch}, 54'd0);
        chk("reset busy", {53'd0, busy}, 54'd0);
        chk("reset err", {53'd0, err}, 54'd0);
        #19;
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle no start busy", {53'd0, busy}, 54'd0);

        // Directed table, issued back to back (each start lands in the IDLE cycle after DONE).
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
                   vecs[i].exp, vecs[i].exp_err, vecs[i].lat, 1'b0);
        end

        // en pulsed and inputs scrambled throughout a mul: captured operands win, one strobe.
        run_op("hs_mul", 3'd2, -27'sd12345, 27'sd678, -54'sd8369910, 1'b0, LONG_LAT, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hs_quiet%0d latch", i), {53'd0, data_latch}, 54'd0);
            chk($sformatf("hs_quiet%0d busy", i), {53'd0, busy}, 54'd0);
        end

        run8("dw8 div", 3'd3, 8'h80, 8'hFF, 16'd128);
        run8("dw8 mul", 3'd2, 8'h80, 8'h80, 16'h4000);

        // Randomized against the reference model.
        for (int i = 0; i < 50; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_d1 = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : DW'($urandom);
            r_d2 = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : DW'($urandom);
            if ($urandom_range(0, 9) == 0) r_d2 = '0;
            e_d3 = ref_res(r_op, r_d1, r_d2, e_err);
            run_op($sformatf("rnd%0d op%0d", i, r_op), r_op, r_d1, r_d2, e_d3, e_err,
                   ref_lat(r_op, r_d2), i[0]);
        end

        // Async reset in the middle of a mul.
        run_op("pre_rst add", 3'd0, 27'sd100, -27'sd250, -54'sd150, 1'b0, 2, 1'b0);
        en = 1'b1; arith = 3'd2; data1 = -27'sd12345; data2 = 27'sd678;
        tick();
        en = 1'b0;
        for (k = 1; k < 10; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid data3", data3, 54'd0);
        chk("rst mid latch", {53'd0, data_latch}, 54'd0);
        chk("rst mid busy", {53'd0, busy}, 54'd0);
        chk("rst mid err", {53'd0, err}, 54'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst hold%0d latch", i), {53'd0, data_latch}, 54'd0);
        end
        #2;
        rst_n = 1'b1;
        run_op("post_rst add", 3'd0, 27'sd3, 27'sd4, 54'sd7, 1'b0, 2, 1'b0);
        for (int i = 0; i < LONG_LAT; i++) begin
            tick();
            chk($sformatf("post_rst quiet%0d", i), {53'd0, data_latch}, 54'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
